prog_loader: RTL and testbench

//  Writer side of the instruction memory. Receives a program image as a byte stream over a

---
 rtl/loader_pkg.sv | 20 ++
 rtl/prog_loader.sv | 136 +++++++++++++
 tb/tb_prog_loader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the program loader
// Purpose: FSM state encoding and image-format constants used by prog_loader.
// Ports:   none (package).
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_W_LO   = 3'd3,
        S_W_HI   = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } loader_state_t;

    localparam logic [7:0] CHK_SEED       = 8'h00;
    localparam int         BYTES_PER_WORD = 2;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program image loader for the instruction memory
// Purpose: parses {cnt_lo, cnt_hi, N x {w_lo, w_hi}, chk}, writes 9-bit words to the
//          instruction memory write port and holds the processor in start until the
//          image has loaded with a good checksum.
// Ports:   clk, reset (sync, active-high); load_req pulse; in_valid/in_data/in_ready
//          byte stream; im_wr_en/im_wr_addr/im_wr_data memory write port; cpu_start,
//          load_done, load_err status levels; words_loaded write count.
module prog_loader
    import loader_pkg::*;
#(
    parameter int D    = 12,
    parameter int W    = 9,
    parameter int MAXW = 2**D
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_req,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         im_wr_en,
    output logic [D-1:0] im_wr_addr,
    output logic [W-1:0] im_wr_data,
    output logic         cpu_start,
    output logic         load_done,
    output logic         load_err,
    output logic [D:0]   words_loaded
);

    loader_state_t state;
    logic [15:0]   rem;       // words still to be received
    logic [7:0]    cnt_lo_q;
    logic [7:0]    w_lo_q;
    logic [7:0]    xsum;
    logic          wr_pend;
    logic [D-1:0]  addr_q;
    logic [W-1:0]  data_q;
    logic [D:0]    wcnt;

    logic          accept;
    logic [15:0]   n_full;

    assign in_ready = (state == S_CNT_LO) || (state == S_CNT_HI) || (state == S_W_LO) ||
                      (state == S_W_HI)   || (state == S_CHK);
    assign accept   = in_valid && in_ready;
    assign n_full   = {in_data, cnt_lo_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            rem      <= '0;
            cnt_lo_q <= '0;
            w_lo_q   <= '0;
            xsum     <= CHK_SEED;
            wr_pend  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            wcnt     <= '0;
        end else begin
            wr_pend <= 1'b0;

            // The write issued this cycle completes; advance the address but never wrap,
            // so an image of exactly MAXW words leaves the address parked at MAXW-1.
            if (wr_pend) begin
                wcnt <= wcnt + (D+1)'(1);
                if (addr_q != {D{1'b1}}) begin
                    addr_q <= addr_q + D'(1);
                end
            end

            if (accept && state != S_CHK) begin
                xsum <= xsum ^ in_data;
            end

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_req) begin
                        state  <= S_CNT_LO;
                        xsum   <= CHK_SEED;
                        addr_q <= '0;
                        wcnt   <= '0;
                    end
                end
                S_CNT_LO: begin
                    if (accept) begin
                        cnt_lo_q <= in_data;
                        state    <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (accept) begin
                        rem <= n_full;
                        if (n_full == 16'd0) begin
                            state <= S_CHK;
                        end else if ({1'b0, n_full} > 17'(MAXW)) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_W_LO;
                        end
                    end
                end
                S_W_LO: begin
                    if (accept) begin
                        w_lo_q <= in_data;
                        state  <= S_W_HI;
                    end
                end
                S_W_HI: begin
                    if (accept) begin
                        // Only bit 0 of the high byte carries data; the rest is padding.
                        data_q  <= W'({in_data[0], w_lo_q});
                        wr_pend <= 1'b1;
                        rem     <= rem - 16'd1;
                        state   <= (rem == 16'd1) ? S_CHK : S_W_LO;
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        state <= (in_data == xsum) ? S_DONE : S_ERR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Gating with reset drops a write that is pending in the very cycle reset arrives.
    assign im_wr_en     = wr_pend && !reset;
    assign im_wr_addr   = addr_q;
    assign im_wr_data   = data_q;
    assign cpu_start    = (state != S_DONE);
    assign load_done    = (state == S_DONE);
    assign load_err     = (state == S_ERR);
    assign words_loaded = wcnt;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

    localparam int D    = 12;
    localparam int W    = 9;
    localparam int MAXW = 4096;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_req;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         im_wr_en;
    logic [D-1:0] im_wr_addr;
    logic [W-1:0] im_wr_data;
    logic         cpu_start;
    logic         load_done;
    logic         load_err;
    logic [D:0]   words_loaded;

    int nvec = 0;
    int nerr = 0;

    logic [7:0]   img[$];
    int           wr_addr_q[$];
    int           wr_data_q[$];
    int           exp_addr[$];
    int           exp_data[$];
    bit           exp_done;
    bit           exp_err;
    int           b2b_data[$];

    prog_loader #(.D(D), .W(W), .MAXW(MAXW)) dut (
        .clk(clk), .reset(reset), .load_req(load_req),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data),
        .cpu_start(cpu_start), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_wr_en === 1'b1) begin
            wr_addr_q.push_back(int'(im_wr_addr));
            wr_data_q.push_back(int'(im_wr_data));
        end
    end

    // Reference: parse the image from the format rules.
    task automatic model_image();
        int n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        n = {img[1], img[0]};
        x = img[0] ^ img[1];
        if (n > MAXW) begin
            exp_done = 0;
            exp_err  = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(int'(img[3+2*i][0]) * 256 + int'(img[2+2*i]));
            x = x ^ img[2+2*i] ^ img[3+2*i];
        end
        exp_done = (img[2+2*n] == x);
        exp_err  = !exp_done;
    endtask

    task automatic make_image(input int n, input bit good);
        logic [7:0] x;
        logic [8:0] w;
        logic [7:0] hi;
        img.delete();
        img.push_back(n[7:0]);
        img.push_back(n[15:8]);
        if (n > MAXW) return;
        for (int i = 0; i < n; i++) begin
            w  = 9'($urandom);
            hi = {7'($urandom), w[8]};
            img.push_back(w[7:0]);
            img.push_back(hi);
        end
        x = 8'h00;
        foreach (img[i]) x = x ^ img[i];
        img.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall, input bit chk_ready);
        int guard;
        repeat (stall) begin
            in_valid = 1'b0;
            if (chk_ready) begin
                nvec++;
                if (in_ready !== 1'b1) begin
                    nerr++;
                    $display("FAIL stall_in_ready got %b exp 1", in_ready);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard == 20) begin
            nerr++;
            $display("FAIL byte_accept_timeout got in_ready=%b exp 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_image(input int stall_max, input int mid_req, input bit chk_ready,
                             input string name);
        wr_addr_q.delete();
        wr_data_q.delete();
        model_image();
        pulse_load_req();
        nvec++;
        if (words_loaded !== '0 || cpu_start !== 1'b1 || load_done !== 1'b0 ||
            load_err !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL %s_start got wl=%0d cs=%b dn=%b er=%b rdy=%b exp 0 1 0 0 1",
                     name, words_loaded, cpu_start, load_done, load_err, in_ready);
        end
        foreach (img[i]) begin
            if (i == mid_req) begin
                in_valid = 1'b0;
                pulse_load_req();
            end
            send_byte(img[i], (stall_max > 0) ? $urandom_range(0, stall_max) : 0, chk_ready);
        end
        // Status is checked on the cycle right after the final byte: every write has
        // already landed and cpu_start reflects DONE immediately.
        nvec++;
        if (wr_addr_q.size() != exp_addr.size()) begin
            nerr++;
            $display("FAIL %s_nwrites got %0d exp %0d", name, wr_addr_q.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                nvec++;
                if (wr_addr_q[i] != exp_addr[i] || wr_data_q[i] != exp_data[i]) begin
                    nerr++;
                    $display("FAIL %s_write%0d got (%0h,%03h) exp (%0h,%03h)", name, i,
                             wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        nvec++;
        if (load_done !== exp_done || load_err !== exp_err || cpu_start !== !exp_done ||
            int'(words_loaded) != exp_addr.size() || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL %s_status got dn=%b er=%b cs=%b wl=%0d rdy=%b exp %b %b %b %0d 0",
                     name, load_done, load_err, cpu_start, words_loaded, in_ready,
                     exp_done, exp_err, !exp_done, exp_addr.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load_req = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; load_req = 1'b0;
        nvec++;
        if (in_ready !== 1'b0 || im_wr_en !== 1'b0 || im_wr_addr !== '0 || im_wr_data !== '0 ||
            cpu_start !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 ||
            words_loaded !== '0) begin
            nerr++;
            $display("FAIL reset_values got rdy=%b we=%b a=%h d=%h cs=%b dn=%b er=%b wl=%0d",
                     in_ready, im_wr_en, im_wr_addr, im_wr_data, cpu_start, load_done,
                     load_err, words_loaded);
        end
        @(posedge clk); #1;
        nvec++;
        if (in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL reset_wins_over_load_req got in_ready=%b exp 0", in_ready);
        end
    endtask

    task automatic test_basic();
        // Checksum of this image is 0xCE.
        img = '{8'h03, 8'h00, 8'h11, 8'h00, 8'h22, 8'h01, 8'hFF, 8'h00, 8'hCE};
        run_image(0, -1, 0, "basic");
        nvec++;
        if (wr_data_q.size() != 3 || wr_data_q[0] != 'h011 || wr_data_q[1] != 'h122 ||
            wr_data_q[2] != 'h0FF || load_done !== 1'b1) begin
            nerr++;
            $display("FAIL basic_const got n=%0d dn=%b exp 3 words 011 122 0FF done",
                     wr_data_q.size(), load_done);
        end
    endtask

    task automatic test_bad_chk();
        img = '{8'h03, 8'h00, 8'h11, 8'h00, 8'h22, 8'h01, 8'hFF, 8'h00, 8'h00};
        run_image(0, -1, 0, "badchk");
        nvec++;
        if (load_err !== 1'b1 || cpu_start !== 1'b1 || wr_data_q.size() != 3) begin
            nerr++;
            $display("FAIL badchk_const got er=%b cs=%b n=%0d exp 1 1 3",
                     load_err, cpu_start, wr_data_q.size());
        end
    endtask

    task automatic test_oversize();
        make_image(MAXW + 1, 1);
        run_image(0, -1, 0, "oversize");
    endtask

    task automatic test_stall();
        make_image(2, 1);
        run_image(0, -1, 0, "b2b");
        b2b_data = wr_data_q;
        run_image(1, -1, 1, "toggle");
        nvec++;
        if (wr_data_q != b2b_data) begin
            nerr++;
            $display("FAIL toggle_vs_b2b got %0d writes exp %0d identical",
                     wr_data_q.size(), b2b_data.size());
        end
    endtask

    task automatic test_busy_load_req();
        make_image(3, 1);
        run_image(0, 4, 0, "busyreq");
    endtask

    task automatic test_reset_mid();
        make_image(3, 1);
        model_image();
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_load_req();
        for (int i = 0; i < 6; i++) send_byte(img[i], 0, 0);
        reset = 1'b1;
        #1;
        nvec++;
        if (im_wr_en !== 1'b0) begin
            nerr++;
            $display("FAIL resetmid_wr_en got %b exp 0", im_wr_en);
        end
        @(posedge clk); #1;
        nvec++;
        if (in_ready !== 1'b0 || im_wr_en !== 1'b0 || im_wr_addr !== '0 || im_wr_data !== '0 ||
            cpu_start !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 ||
            words_loaded !== '0) begin
            nerr++;
            $display("FAIL resetmid_values got rdy=%b we=%b a=%h d=%h cs=%b wl=%0d",
                     in_ready, im_wr_en, im_wr_addr, im_wr_data, cpu_start, words_loaded);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        nvec++;
        if (wr_data_q.size() != 1 || wr_data_q[0] != exp_data[0] || wr_addr_q[0] != 0) begin
            nerr++;
            $display("FAIL resetmid_writes got %0d writes exp 1 (0,%03h)",
                     wr_data_q.size(), exp_data[0]);
        end
    endtask

    task automatic test_zero_after_done();
        make_image(2, 1);
        run_image(0, -1, 0, "predone");
        make_image(0, 1);
        run_image(0, -1, 0, "zero");
    endtask

    task automatic test_full();
        make_image(MAXW, 1);
        run_image(0, -1, 0, "full");
        nvec++;
        if (wr_addr_q.size() != MAXW || wr_addr_q[MAXW-1] != MAXW - 1 ||
            int'(words_loaded) != MAXW) begin
            nerr++;
            $display("FAIL full_last got n=%0d wl=%0d exp %0d last addr %0h",
                     wr_addr_q.size(), words_loaded, MAXW, MAXW - 1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            make_image($urandom_range(0, 6), $urandom_range(0, 1) == 1);
            run_image($urandom_range(0, 2), -1, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_chk();
        test_oversize();
        test_stall();
        test_busy_load_req();
        test_reset_mid();
        test_zero_after_done();
        test_full();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
